// File: rtl/sha1_pkg.sv
// Shared constants for the sha1 core register bus and the block sequencer.
//   ADDR_*           register map of the sha1 core
//   CTRL_INIT/NEXT   control-register values that start a first / continuation block
//   STATUS_READY_BIT position of the ready flag in the status register
//   seq_state_t      sequencer state encoding
package sha1_pkg;

  localparam logic [7:0]  ADDR_CTRL    = 8'h08;
  localparam logic [7:0]  ADDR_STATUS  = 8'h09;
  localparam logic [7:0]  ADDR_BLOCK0  = 8'h10;
  localparam logic [7:0]  ADDR_DIGEST0 = 8'h20;

  localparam logic [31:0] CTRL_INIT = 32'h0000_0001;
  localparam logic [31:0] CTRL_NEXT = 32'h0000_0002;

  localparam int STATUS_READY_BIT = 0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    CTRL   = 3'd2,
    GAP    = 3'd3,
    POLL   = 3'd4,
    DIGEST = 3'd5,
    OUT    = 3'd6,
    ERR    = 3'd7
  } seq_state_t;

endpackage

// File: rtl/sha1_block_sequencer.sv
// Drives the sha1 core register bus from a 32-bit block word stream and
// returns the 160-bit digest on a valid/ready port.
//   clk, reset_n               clock, asynchronous active-low reset
//   blk_valid/blk_ready        block word stream (blk_word, blk_first, blk_last)
//   dig_valid/dig_ready        digest output (dig_word, [159:128] = word 0)
//   busy, err, err_clr         status: busy outside IDLE, sticky error and its clear
//   core_*                     registered sha1 register-bus signals
//   dbg_state                  current FSM state
//
// Handshakes: a transfer happens on a rising clk edge where valid & ready are
// both 1. A producer holding valid keeps its data stable until that edge;
// ready may depend on state only, never on valid.
module sha1_block_sequencer
  import sha1_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [31:0]  blk_word,
  input  logic         blk_first,
  input  logic         blk_last,
  output logic         dig_valid,
  input  logic         dig_ready,
  output logic [159:0] dig_word,
  output logic         busy,
  output logic         err,
  input  logic         err_clr,
  output logic         core_cs,
  output logic         core_we,
  output logic [7:0]   core_address,
  output logic [31:0]  core_write_data,
  input  logic [31:0]  core_read_data,
  input  logic         core_error,
  output logic [2:0]   dbg_state
);

  localparam int PW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PW-1:0] POLL_LIMIT = PW'(TIMEOUT_CYCLES);

  seq_state_t     state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [2:0]     rd_q, rd_d;
  logic [PW-1:0]  poll_q, poll_d;
  logic           first_q, first_d, last_q, last_d;
  logic           open_q, open_d, err_q, err_d, err_event;
  logic [159:0]   dig_q, dig_d;
  logic           cs_q, cs_d, we_q, we_d;
  logic [7:0]     addr_q, addr_d;
  logic [31:0]    wdata_q, wdata_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
      poll_q  <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      open_q  <= 1'b0;
      err_q   <= 1'b0;
      dig_q   <= '0;
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      poll_q  <= poll_d;
      first_q <= first_d;
      last_q  <= last_d;
      open_q  <= open_d;
      err_q   <= err_d;
      dig_q   <= dig_d;
      cs_q    <= cs_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // The bus registers hold the access performed in the *next* cycle, so a
  // status or digest read is evaluated in the cycle it is on the bus.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    poll_d    = poll_q;
    first_d   = first_q;
    last_d    = last_q;
    open_d    = open_q;
    dig_d     = dig_q;
    cs_d      = 1'b0;
    we_d      = 1'b0;
    addr_d    = '0;
    wdata_d   = '0;
    err_event = 1'b0;

    case (state_q)
      IDLE: begin
        if (blk_valid) begin
          cs_d    = 1'b1;
          we_d    = 1'b1;
          addr_d  = ADDR_BLOCK0;
          wdata_d = blk_word;
          cnt_d   = 4'd1;
          first_d = blk_first;
          last_d  = blk_last;
          // Continuation with no open message: flag it, hash as a fresh message.
          if (!blk_first && !open_q) begin
            err_event = 1'b1;
            first_d   = 1'b1;
          end
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (blk_valid) begin
          cs_d    = 1'b1;
          we_d    = 1'b1;
          addr_d  = ADDR_BLOCK0 + {4'h0, cnt_q};
          wdata_d = blk_word;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd15) state_d = CTRL;
        end
      end
      CTRL: begin
        cs_d    = 1'b1;
        we_d    = 1'b1;
        addr_d  = ADDR_CTRL;
        wdata_d = first_q ? CTRL_INIT : CTRL_NEXT;
        open_d  = 1'b1;
        poll_d  = '0;
        state_d = GAP;
      end
      GAP: begin
        state_d = POLL;
      end
      POLL: begin
        cs_d   = 1'b1;
        addr_d = ADDR_STATUS;
        if (cs_q && !we_q) begin
          if (core_read_data[STATUS_READY_BIT]) begin
            if (last_q) begin
              rd_d    = 3'd0;
              addr_d  = ADDR_DIGEST0;
              state_d = DIGEST;
            end else begin
              cs_d    = 1'b0;
              addr_d  = '0;
              state_d = IDLE;
            end
          end else begin
            if (poll_q != POLL_LIMIT) poll_d = poll_q + PW'(1);
            if (poll_q + PW'(1) == POLL_LIMIT) begin
              err_event = 1'b1;
              cs_d      = 1'b0;
              addr_d    = '0;
              state_d   = ERR;
            end
          end
        end
      end
      DIGEST: begin
        case (rd_q)
          3'd0:    dig_d[159:128] = core_read_data;
          3'd1:    dig_d[127:96]  = core_read_data;
          3'd2:    dig_d[95:64]   = core_read_data;
          3'd3:    dig_d[63:32]   = core_read_data;
          default: dig_d[31:0]    = core_read_data;
        endcase
        if (rd_q == 3'd4) begin
          rd_d    = 3'd0;
          state_d = OUT;
        end else begin
          rd_d   = rd_q + 3'd1;
          cs_d   = 1'b1;
          addr_d = ADDR_DIGEST0 + {5'h0, rd_q + 3'd1};
        end
      end
      OUT: begin
        if (dig_ready) begin
          open_d  = 1'b0;
          state_d = IDLE;
        end
      end
      ERR: begin
        if (err_clr) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A core error on any bus access aborts the message and discards the digest.
    if (cs_q && core_error) begin
      err_event = 1'b1;
      state_d   = ERR;
      cs_d      = 1'b0;
      we_d      = 1'b0;
      addr_d    = '0;
      wdata_d   = '0;
      dig_d     = '0;
    end

    if (state_d == ERR) open_d = 1'b0;

    // A new error outranks a simultaneous clear.
    err_d = err_event | (err_q & ~err_clr);
  end

  assign blk_ready       = (state_q == IDLE) || (state_q == LOAD);
  assign dig_valid       = (state_q == OUT);
  assign dig_word        = dig_q;
  assign busy            = (state_q != IDLE);
  assign err             = err_q;
  assign core_cs         = cs_q;
  assign core_we         = we_q;
  assign core_address    = addr_q;
  assign core_write_data = wdata_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_sha1_block_sequencer.sv
`timescale 1ns/1ps
module tb_sha1_block_sequencer;

  localparam int TIMEOUT = 16;
  localparam logic [159:0] DIG_ABC = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
  localparam logic [159:0] DIG_TWO = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic         blk_valid = 1'b0, blk_first = 1'b0, blk_last = 1'b0;
  logic [31:0]  blk_word = '0;
  logic         blk_ready, dig_valid, busy, err;
  logic         dig_ready = 1'b0, err_clr = 1'b0;
  logic [159:0] dig_word;
  logic         core_cs, core_we, core_error;
  logic [7:0]   core_address;
  logic [31:0]  core_write_data, core_read_data;
  logic [2:0]   dbg_state;

  sha1_block_sequencer #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_word(blk_word),
    .blk_first(blk_first), .blk_last(blk_last),
    .dig_valid(dig_valid), .dig_ready(dig_ready), .dig_word(dig_word),
    .busy(busy), .err(err), .err_clr(err_clr),
    .core_cs(core_cs), .core_we(core_we), .core_address(core_address),
    .core_write_data(core_write_data), .core_read_data(core_read_data),
    .core_error(core_error), .dbg_state(dbg_state)
  );

  // ---------------- sha1 core model ----------------
  logic [31:0] m_blk [16];
  logic [31:0] m_h [5];
  logic [31:0] h_next [5];
  logic        m_ready;
  int          m_cnt;
  logic        stuck_mode = 1'b0, err_mode = 1'b0;
  logic [31:0] ctrl_log [$];

  task automatic compress(input logic init);
    logic [31:0] w [80];
    logic [31:0] a, b, c, d, e, f, k, t;
    logic [31:0] h0 [5];
    if (init) begin
      h0[0] = 32'h67452301; h0[1] = 32'hefcdab89; h0[2] = 32'h98badcfe;
      h0[3] = 32'h10325476; h0[4] = 32'hc3d2e1f0;
    end else begin
      for (int i = 0; i < 5; i++) h0[i] = m_h[i];
    end
    for (int i = 0; i < 16; i++) w[i] = m_blk[i];
    for (int i = 16; i < 80; i++) begin
      t = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
      w[i] = {t[30:0], t[31]};
    end
    a = h0[0]; b = h0[1]; c = h0[2]; d = h0[3]; e = h0[4];
    for (int i = 0; i < 80; i++) begin
      if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5a827999; end
      else if (i < 40) begin f = b ^ c ^ d;                   k = 32'h6ed9eba1; end
      else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8f1bbcdc; end
      else             begin f = b ^ c ^ d;                   k = 32'hca62c1d6; end
      t = {a[26:0], a[31:27]} + f + e + k + w[i];
      e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = t;
    end
    h_next[0] = h0[0] + a; h_next[1] = h0[1] + b; h_next[2] = h0[2] + c;
    h_next[3] = h0[3] + d; h_next[4] = h0[4] + e;
  endtask

  assign core_error = err_mode & core_cs & core_we;

  always_comb begin
    core_read_data = 32'h0;
    if (core_cs && !core_we) begin
      case (core_address)
        8'h09:   core_read_data = {31'h0, m_ready};
        8'h20:   core_read_data = m_h[0];
        8'h21:   core_read_data = m_h[1];
        8'h22:   core_read_data = m_h[2];
        8'h23:   core_read_data = m_h[3];
        8'h24:   core_read_data = m_h[4];
        default: core_read_data = 32'h0;
      endcase
    end
  end

  // Ready drops on a control write and returns four cycles later.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ready <= 1'b1;
      m_cnt   <= 0;
    end else if (core_cs && core_we && !core_error) begin
      if (core_address[7:4] == 4'h1) m_blk[core_address[3:0]] <= core_write_data;
      else if (core_address == 8'h08) begin
        ctrl_log.push_back(core_write_data);
        compress(core_write_data[0]);
        for (int i = 0; i < 5; i++) m_h[i] <= h_next[i];
        m_ready <= 1'b0;
        m_cnt   <= 4;
      end
    end else begin
      if (m_cnt != 0) m_cnt <= m_cnt - 1;
      if (m_cnt <= 1 && !stuck_mode) m_ready <= 1'b1;
    end
  end

  // ---------------- bus / output monitors ----------------
  int   status_reads = 0, dv_rises = 0;
  logic dv_prev = 1'b0;
  always @(posedge clk) begin
    if (core_cs && !core_we && core_address == 8'h09) status_reads++;
    if (dig_valid && !dv_prev) dv_rises++;
    dv_prev = dig_valid;
  end

  // ---------------- scoreboard / checking ----------------
  logic [159:0] exp_q [$];
  int n_checks = 0, n_pass = 0;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  logic [31:0] blk_buf [16];

  task automatic load_abc();
    for (int i = 0; i < 16; i++) blk_buf[i] = 32'h0;
    blk_buf[0] = 32'h61626380; blk_buf[15] = 32'h00000018;
  endtask

  task automatic load_two_1();
    blk_buf[0]  = 32'h61626364; blk_buf[1]  = 32'h62636465; blk_buf[2]  = 32'h63646566;
    blk_buf[3]  = 32'h64656667; blk_buf[4]  = 32'h65666768; blk_buf[5]  = 32'h66676869;
    blk_buf[6]  = 32'h6768696a; blk_buf[7]  = 32'h68696a6b; blk_buf[8]  = 32'h696a6b6c;
    blk_buf[9]  = 32'h6a6b6c6d; blk_buf[10] = 32'h6b6c6d6e; blk_buf[11] = 32'h6c6d6e6f;
    blk_buf[12] = 32'h6d6e6f70; blk_buf[13] = 32'h6e6f7071; blk_buf[14] = 32'h80000000;
    blk_buf[15] = 32'h00000000;
  endtask

  task automatic load_two_2();
    for (int i = 0; i < 15; i++) blk_buf[i] = 32'h0;
    blk_buf[15] = 32'h000001c0;
  endtask

  // Called and returns at a negedge; the word is accepted at the posedge in between.
  task automatic send_word(input logic [31:0] w, input logic f, input logic l);
    int n = 0;
    blk_valid = 1'b1; blk_word = w; blk_first = f; blk_last = l;
    while (!blk_ready && n < 500) begin @(negedge clk); n++; end
    if (!blk_ready) check("blk_ready_timeout", 160'(blk_ready), 160'(1));
    @(negedge clk);
  endtask

  task automatic send_block(input logic f, input logic l, input logic gaps,
                            input int first_idx, input int nwords);
    for (int i = first_idx; i < nwords; i++) begin
      send_word(blk_buf[i], f, l);
      if (gaps) begin blk_valid = 1'b0; @(negedge clk); end
    end
    blk_valid = 1'b0;
  endtask

  task automatic wait_digest(input int hold, output int lat);
    int n = 0;
    int unstable = 0;
    logic [159:0] snap, exp;
    lat = -1;
    while (!dig_valid && n < 1000) begin @(negedge clk); n++; end
    if (!dig_valid) begin
      check("dig_valid_timeout", 160'(dig_valid), 160'(1));
    end else begin
      lat = n;
      snap = dig_word;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (!dig_valid || dig_word !== snap) unstable++;
      end
      if (hold > 0) check("dig_hold_stable", 160'(unstable), 160'(0));
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 160'h0;
      check("digest", dig_word, exp);
      dig_ready = 1'b1;
      @(negedge clk);
      dig_ready = 1'b0;
      check("dig_valid_drop", 160'(dig_valid), 160'(0));
    end
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int lat, base, rises;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_busy", 160'(busy), 160'(0));
    check("rst_err", 160'(err), 160'(0));
    check("rst_dig_valid", 160'(dig_valid), 160'(0));
    check("rst_dig_word", dig_word, 160'h0);
    check("rst_core_bus", 160'({core_cs, core_we, core_address, core_write_data}), 160'h0);

    // Test 1: "abc"
    load_abc();
    exp_q.push_back(DIG_ABC);
    ctrl_log.delete();
    base = status_reads;
    send_word(blk_buf[0], 1'b1, 1'b1);
    check("first_write_bus", 160'({core_cs, core_we, core_address, core_write_data}),
          160'({1'b1, 1'b1, 8'h10, 32'h61626380}));
    send_block(1'b1, 1'b1, 1'b0, 1, 16);
    wait_digest(0, lat);
    check("t1_latency", 160'(lat), 160'(12));
    check("t1_status_reads", 160'(status_reads - base), 160'(4));
    check("t1_err", 160'(err), 160'(0));
    check("t1_busy_after", 160'(busy), 160'(0));
    check("t1_ctrl_init", 160'(ctrl_log.size() > 0 ? ctrl_log[0] : 32'hdead), 160'(32'h1));

    // Test 2: two-block message
    ctrl_log.delete();
    rises = dv_rises;
    exp_q.push_back(DIG_TWO);
    load_two_1();
    send_block(1'b1, 1'b0, 1'b0, 0, 16);
    load_two_2();
    send_block(1'b0, 1'b1, 1'b0, 0, 16);
    wait_digest(0, lat);
    check("t2_one_dig_valid", 160'(dv_rises - rises), 160'(1));
    check("t2_ctrl_count", 160'(ctrl_log.size()), 160'(2));
    if (ctrl_log.size() == 2)
      check("t2_ctrl_init_next", 160'({ctrl_log[0], ctrl_log[1]}), 160'({32'h1, 32'h2}));
    check("t2_err", 160'(err), 160'(0));

    // Test 3: input gaps and output backpressure
    load_abc();
    exp_q.push_back(DIG_ABC);
    send_block(1'b1, 1'b1, 1'b1, 0, 16);
    wait_digest(10, lat);

    // Test 4: status never ready
    stuck_mode = 1'b1;
    base = status_reads;
    load_abc();
    send_block(1'b1, 1'b1, 1'b0, 0, 16);
    begin
      int n = 0;
      while (!err && n < 300) begin @(negedge clk); n++; end
    end
    repeat (3) @(negedge clk);
    check("t4_status_reads", 160'(status_reads - base), 160'(TIMEOUT));
    check("t4_err", 160'(err), 160'(1));
    check("t4_busy", 160'(busy), 160'(1));
    check("t4_state_err", 160'(dbg_state), 160'(3'd7));
    stuck_mode = 1'b0;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("t4_clr_busy", 160'(busy), 160'(0));
    check("t4_clr_err", 160'(err), 160'(0));
    @(negedge clk);

    // Test 5: reset while word 7 is offered
    load_abc();
    send_block(1'b1, 1'b1, 1'b0, 0, 7);
    blk_valid = 1'b1; blk_word = blk_buf[7];
    reset_n = 1'b0;
    #1;
    check("t5_rst_busy", 160'(busy), 160'(0));
    check("t5_rst_core_bus", 160'({core_cs, core_we, core_address, core_write_data}), 160'h0);
    check("t5_rst_dig", 160'({dig_valid, err, dig_word}), 160'h0);
    blk_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    exp_q.push_back(DIG_ABC);
    send_block(1'b1, 1'b1, 1'b0, 0, 16);
    wait_digest(0, lat);
    check("t5_err", 160'(err), 160'(0));

    // Test 6a: continuation with no open message, with err_clr held on the same edge
    ctrl_log.delete();
    load_abc();
    exp_q.push_back(DIG_ABC);
    err_clr = 1'b1;
    send_word(blk_buf[0], 1'b0, 1'b1);
    err_clr = 1'b0;
    check("t6_err_wins_clr", 160'(err), 160'(1));
    send_block(1'b0, 1'b1, 1'b0, 1, 16);
    wait_digest(0, lat);
    check("t6_err_sticky", 160'(err), 160'(1));
    check("t6_ctrl_as_init", 160'(ctrl_log.size() > 0 ? ctrl_log[0] : 32'hdead), 160'(32'h1));
    pulse_clr();
    check("t6_err_cleared", 160'(err), 160'(0));

    // Test 6b: core error on a write
    rises = dv_rises;
    err_mode = 1'b1;
    send_word(blk_buf[0], 1'b1, 1'b1);
    blk_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("t6b_err", 160'(err), 160'(1));
    check("t6b_state_err", 160'(dbg_state), 160'(3'd7));
    check("t6b_no_dig", 160'(dv_rises - rises), 160'(0));
    check("t6b_dig_dropped", dig_word, 160'h0);
    err_mode = 1'b0;
    pulse_clr();
    check("t6b_recovered", 160'({busy, err}), 160'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog so a stuck DUT never hangs the run.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
